// File: rtl/id_ex_operand_stage_if.sv
// Bus between decode, the ID/EX operand stage and the ALU.
// The stage is the slave; decode/bypass/ALU together form the master side.
interface id_ex_operand_stage_if #(parameter int XLEN = 32);
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [4:0]      id_rs1_addr;
  logic [4:0]      id_rs2_addr;
  logic [XLEN-1:0] id_rs1_data;
  logic [XLEN-1:0] id_rs2_data;
  logic [XLEN-1:0] id_imm;
  logic [4:0]      id_rd_addr;
  logic            id_reg_write;
  logic [3:0]      id_alu_ctrl;
  logic [1:0]      id_a_sel;
  logic            id_b_sel;
  logic            stall;
  logic            flush;
  logic [4:0]      exmem_rd;
  logic            exmem_we;
  logic [XLEN-1:0] exmem_result;
  logic [4:0]      memwb_rd;
  logic            memwb_we;
  logic [XLEN-1:0] memwb_result;
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [3:0]      alu_ctrl;
  logic [XLEN-1:0] ex_store_data;
  logic [4:0]      ex_rd_addr;
  logic            ex_reg_write;
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc;
  logic [1:0]      fwd_a;
  logic [1:0]      fwd_b;

  modport master (
    output id_valid, id_pc, id_rs1_addr, id_rs2_addr, id_rs1_data, id_rs2_data,
           id_imm, id_rd_addr, id_reg_write, id_alu_ctrl, id_a_sel, id_b_sel,
           stall, flush, exmem_rd, exmem_we, exmem_result,
           memwb_rd, memwb_we, memwb_result,
    input  alu_a, alu_b, alu_ctrl, ex_store_data, ex_rd_addr, ex_reg_write,
           ex_valid, ex_pc, fwd_a, fwd_b
  );

  modport slave (
    input  id_valid, id_pc, id_rs1_addr, id_rs2_addr, id_rs1_data, id_rs2_data,
           id_imm, id_rd_addr, id_reg_write, id_alu_ctrl, id_a_sel, id_b_sel,
           stall, flush, exmem_rd, exmem_we, exmem_result,
           memwb_rd, memwb_we, memwb_result,
    output alu_a, alu_b, alu_ctrl, ex_store_data, ex_rd_addr, ex_reg_write,
           ex_valid, ex_pc, fwd_a, fwd_b
  );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with stall/flush plus EX/MEM and MEM/WB operand forwarding.
// Handshake: no valid/ready; ex_valid qualifies every output, stall holds, flush bubbles.
module id_ex_operand_stage (
  input  logic              clk,
  input  logic              rst_n,
  id_ex_operand_stage_if.slave bus
);
  localparam int XLEN = 32;

  logic            r_valid;
  logic [XLEN-1:0] r_pc;
  logic [4:0]      r_rs1_addr;
  logic [4:0]      r_rs2_addr;
  logic [XLEN-1:0] r_rs1_data;
  logic [XLEN-1:0] r_rs2_data;
  logic [XLEN-1:0] r_imm;
  logic [4:0]      r_rd_addr;
  logic            r_reg_write;
  logic [3:0]      r_alu_ctrl;
  logic [1:0]      r_a_sel;
  logic            r_b_sel;

  logic            w_refresh_rs1;
  logic            w_refresh_rs2;
  logic [XLEN-1:0] w_rs1_val;
  logic [XLEN-1:0] w_rs2_val;
  logic [1:0]      w_fwd_a;
  logic [1:0]      w_fwd_b;
  logic [XLEN-1:0] w_alu_a;
  logic [XLEN-1:0] w_alu_b;

  // A producer retiring through MEM/WB during a stall would otherwise be lost.
  assign w_refresh_rs1 = bus.memwb_we && (bus.memwb_rd != 5'd0) && (bus.memwb_rd == r_rs1_addr);
  assign w_refresh_rs2 = bus.memwb_we && (bus.memwb_rd != 5'd0) && (bus.memwb_rd == r_rs2_addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid     <= 1'b0;
      r_pc        <= '0;
      r_rs1_addr  <= '0;
      r_rs2_addr  <= '0;
      r_rs1_data  <= '0;
      r_rs2_data  <= '0;
      r_imm       <= '0;
      r_rd_addr   <= '0;
      r_reg_write <= 1'b0;
      r_alu_ctrl  <= '0;
      r_a_sel     <= '0;
      r_b_sel     <= 1'b0;
    end else if (bus.flush) begin
      r_valid     <= 1'b0;
      r_pc        <= '0;
      r_rs1_addr  <= '0;
      r_rs2_addr  <= '0;
      r_rs1_data  <= '0;
      r_rs2_data  <= '0;
      r_imm       <= '0;
      r_rd_addr   <= '0;
      r_reg_write <= 1'b0;
      r_alu_ctrl  <= '0;
      r_a_sel     <= '0;
      r_b_sel     <= 1'b0;
    end else if (bus.stall) begin
      if (w_refresh_rs1) r_rs1_data <= bus.memwb_result;
      if (w_refresh_rs2) r_rs2_data <= bus.memwb_result;
    end else begin
      r_valid     <= bus.id_valid;
      r_pc        <= bus.id_pc;
      r_rs1_addr  <= bus.id_rs1_addr;
      r_rs2_addr  <= bus.id_rs2_addr;
      r_rs1_data  <= bus.id_rs1_data;
      r_rs2_data  <= bus.id_rs2_data;
      r_imm       <= bus.id_imm;
      r_rd_addr   <= bus.id_rd_addr;
      r_reg_write <= bus.id_reg_write & bus.id_valid;
      r_alu_ctrl  <= bus.id_alu_ctrl;
      r_a_sel     <= bus.id_a_sel;
      r_b_sel     <= bus.id_b_sel;
    end
  end

  // EX/MEM beats MEM/WB because it is the younger producer; x0 is never forwarded.
  always_comb begin
    w_fwd_a   = 2'b00;
    w_rs1_val = r_rs1_data;
    if (r_rs1_addr != 5'd0) begin
      if (bus.exmem_we && (bus.exmem_rd == r_rs1_addr)) begin
        w_fwd_a   = 2'b10;
        w_rs1_val = bus.exmem_result;
      end else if (bus.memwb_we && (bus.memwb_rd == r_rs1_addr)) begin
        w_fwd_a   = 2'b01;
        w_rs1_val = bus.memwb_result;
      end
    end

    w_fwd_b   = 2'b00;
    w_rs2_val = r_rs2_data;
    if (r_rs2_addr != 5'd0) begin
      if (bus.exmem_we && (bus.exmem_rd == r_rs2_addr)) begin
        w_fwd_b   = 2'b10;
        w_rs2_val = bus.exmem_result;
      end else if (bus.memwb_we && (bus.memwb_rd == r_rs2_addr)) begin
        w_fwd_b   = 2'b01;
        w_rs2_val = bus.memwb_result;
      end
    end

    case (r_a_sel)
      2'b00:   w_alu_a = w_rs1_val;
      2'b01:   w_alu_a = r_pc;
      default: w_alu_a = '0;
    endcase

    w_alu_b = r_b_sel ? r_imm : w_rs2_val;
  end

  assign bus.alu_a         = w_alu_a;
  assign bus.alu_b         = w_alu_b;
  assign bus.alu_ctrl      = r_alu_ctrl;
  assign bus.ex_store_data = w_rs2_val;
  assign bus.ex_rd_addr    = r_rd_addr;
  assign bus.ex_reg_write  = r_reg_write & r_valid;
  assign bus.ex_valid      = r_valid;
  assign bus.ex_pc         = r_pc;
  assign bus.fwd_a         = w_fwd_a;
  assign bus.fwd_b         = w_fwd_b;
endmodule

// File: doc/id_ex_operand_stage.md
# id_ex_operand_stage

ID/EX pipeline register and operand-select/forwarding stage that sits directly upstream of the ALU. It captures decoded instruction fields once per cycle and holds them on a stall or clears them on a flush. From the registered fields plus the EX/MEM and MEM/WB result buses it combinationally produces the ALU operands `a`, `b` and `ctrl`. It also passes the destination and store-data fields downstream.

## Interface
- XLEN, 32: datapath width; the ALU is 32-bit, so only 32 is supported.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- id_valid  input  1  decode slot holds a real instruction
- id_pc  input  32  instruction PC
- id_rs1_addr, id_rs2_addr  input  5  source register indices
- id_rs1_data, id_rs2_data  input  32  register-file read data
- id_imm  input  32  sign-extended immediate
- id_rd_addr  input  5  destination index
- id_reg_write  input  1  instruction writes rd
- id_alu_ctrl  input  4  ALU operation code, passed through unchanged
- id_a_sel  input  2  00 = rs1, 01 = pc, 10 = zero, 11 = reserved (zero)
- id_b_sel  input  1  0 = rs2, 1 = imm
- stall  input  1  hold the current contents
- flush  input  1  replace the contents with a bubble
- exmem_rd  input  5  destination of the EX/MEM instruction
- exmem_we  input  1  EX/MEM instruction writes rd
- exmem_result  input  32  EX/MEM ALU result
- memwb_rd  input  5  destination of the MEM/WB instruction
- memwb_we  input  1  MEM/WB instruction writes rd
- memwb_result  input  32  writeback value
- alu_a  output  32  ALU operand a
- alu_b  output  32  ALU operand b
- alu_ctrl  output  4  registered id_alu_ctrl
- ex_store_data  output  32  forwarded rs2 value, regardless of b_sel
- ex_rd_addr  output  5  registered rd
- ex_reg_write  output  1  registered reg_write, gated by valid
- ex_valid  output  1  stage holds a real instruction
- ex_pc  output  32  registered PC
- fwd_a, fwd_b  output  2  debug: forward source applied to rs1 / rs2 (00 = none, 01 = MEM/WB, 10 = EX/MEM)

## Operation
- Register update at each rising edge, first matching rule wins:
  - flush = 1: load a bubble. valid = 0, reg_write = 0, rd = 0, alu_ctrl = 0000, rs addresses = 0, all data fields = 0.
  - stall = 1 (flush = 0): hold every field, with one exception. If memwb_we = 1, memwb_rd != 0 and memwb_rd equals a held rs address, that held data register is overwritten with memwb_result (refresh). This prevents losing a value whose producer retires during the stall.
  - Otherwise: capture all id_* fields. reg_write captured as id_reg_write & id_valid.
- Forwarding for each source (rs1, rs2), using the registered rs address:
  - Source address 0: never forwarded; the value is the registered data.
  - EX/MEM forward when exmem_we = 1 and exmem_rd equals the address.
  - Else MEM/WB forward when memwb_we = 1 and memwb_rd equals the address.
  - Else the registered data.
  - EX/MEM has priority over MEM/WB when both match.
- Forwarding is applied regardless of ex_valid. Downstream qualifies results with ex_valid.
- alu_a = fwd_rs1 / ex_pc / 0 per the registered a_sel.
- alu_b = fwd_rs2 when b_sel = 0, else the registered imm.
- ex_store_data is always fwd_rs2.
- fwd_a / fwd_b report the selected source even when a_sel or b_sel does not use it.

## Timing
- Reset (rst_n low, asynchronous): all registers are 0, so ex_valid = 0, ex_reg_write = 0, alu_ctrl = 0000, ex_pc = 0 and ex_rd_addr = 0.
  - alu_a = alu_b = 0 while the forwarding buses are inactive.
  - Deassertion takes effect at the first rising edge at which rst_n is high.
- Latency: id_* sampled at edge N appear on the ex_* outputs after edge N.
- alu_a, alu_b, ex_store_data and fwd_* are combinational from the registers and the current-cycle exmem_* / memwb_* inputs, with no extra cycle.
- stall and flush are sampled at the same edge as the id_* inputs; flush dominates stall.
- Reset mid-stall discards the held instruction.

## Test plan
- addi: reset release; edge 1 captures valid = 1, rs1 = x1 with data 5, imm = 7, b_sel = 1, ctrl = 0000 → after edge 1: alu_a = 5, alu_b = 7, alu_ctrl = 0000, ex_valid = 1.
- EX/MEM forward: registered rs1 = x3, exmem_rd = 3, exmem_we = 1, exmem_result = 0xDEADBEEF → alu_a = 0xDEADBEEF, fwd_a = 10.
- Priority: rs2 = x4, b_sel = 0; EX/MEM (rd = 4, result 0x11) and MEM/WB (rd = 4, result 0x22) both active → alu_b = 0x11, fwd_b = 10.
- x0 guard: rs1 = x0, exmem_rd = 0, exmem_we = 1, exmem_result = 0xFFFFFFFF → alu_a = 0, fwd_a = 00.
- Stall with refresh: capture rs1 = x5 with data 1; stall for 2 cycles; in the first stall cycle memwb_rd = 5, memwb_we = 1, memwb_result = 9, and the buses are idle afterwards → alu_a = 9 after release. A mid-stall async reset drops ex_valid to 0 immediately.
- Flush vs stall: stall = 1 and flush = 1 at the same edge with id_valid = 1 → ex_valid = 0, ex_reg_write = 0, alu_ctrl = 0000 on the next cycle.
